// File: rtl/audio_pkg.sv
// audio_pkg: shared widths, PWM period length, LFSR constants and sample-to-level processing
package audio_pkg;
  localparam int SAMPLE_W = 16;
  localparam int LEVEL_W = 8;
  localparam int PERIOD_LEN = 256;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'h002D;
  function automatic logic signed [LEVEL_W-1:0] process(input logic signed [SAMPLE_W-1:0] sample, input logic [2:0] atten, input logic [7:0] rnd);
    logic signed [SAMPLE_W-1:0] s;
    logic signed [SAMPLE_W:0] r;
    logic signed [8:0] q;
    s = sample >>> atten;
    r = {s[SAMPLE_W-1], s} + {9'd0, rnd};
    q = 9'(r >>> 8);
    return q[8] != q[7] ? (q[8] ? 8'sh80 : 8'sh7F) : q[7:0];
  endfunction
endpackage

// File: rtl/audio_pwm_feeder_if.sv
// audio_pwm_feeder_if: sample handshake and PWM-side outputs of the feeder
interface audio_pwm_feeder_if import audio_pkg::*; #(parameter int FIFO_DEPTH = 8);
  logic signed [SAMPLE_W-1:0] sample_in;
  logic sample_valid_in;
  logic sample_ready_out;
  logic [2:0] atten_in;
  logic signed [LEVEL_W-1:0] level_out;
  logic tick_out;
  logic underflow_out;
  logic [$clog2(FIFO_DEPTH):0] fifo_count_out;
  modport master(output sample_in, sample_valid_in, atten_in, input sample_ready_out, level_out, tick_out, underflow_out, fifo_count_out);
  modport slave(input sample_in, sample_valid_in, atten_in, output sample_ready_out, level_out, tick_out, underflow_out, fifo_count_out);
endinterface

// File: rtl/sample_fifo.sv
// sample_fifo: first-word-fall-through sample queue; callers never push when full or pop when empty
module sample_fifo #(parameter int DEPTH = 8, parameter int W = 16) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic push,
  input  logic pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr, rd;
  assign dout = mem[rd];
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  always_ff @(posedge clk_in)
    if (push) mem[wr] <= din;
  always_ff @(posedge clk_in)
    if (rst_in) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else begin
      if (push) wr <= wr + 1'b1;
      if (pop) rd <= rd + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
endmodule

// File: rtl/audio_pwm_feeder.sv
// audio_pwm_feeder: buffers audio samples and hands one processed level to the PWM stage per period.
// Optional PWM_DITHER_EN replaces the fixed rounding offset with LFSR dither.
module audio_pwm_feeder import audio_pkg::*; #(
  parameter int TICK_DIV = 4,
  parameter int FIFO_DEPTH = 8
) (
  input logic clk_in,
  input logic rst_in,
  audio_pwm_feeder_if.slave bus
);
  logic [7:0] div, period, rnd;
  logic tick, boundary, push, pop, full, empty, underflow;
  logic signed [SAMPLE_W-1:0] head;
  logic signed [LEVEL_W-1:0] level;
  assign tick = div == 8'(TICK_DIV-1);
  assign boundary = tick && period == 8'(PERIOD_LEN-1);
  assign push = bus.sample_valid_in && bus.sample_ready_out;
  assign pop = boundary && !empty;
  assign bus.sample_ready_out = !full && !rst_in;
  assign bus.tick_out = tick;
  assign bus.level_out = level;
  assign bus.underflow_out = underflow;
  sample_fifo #(.DEPTH(FIFO_DEPTH), .W(SAMPLE_W)) u_fifo (
    .clk_in(clk_in), .rst_in(rst_in), .push(push), .pop(pop), .din(bus.sample_in),
    .dout(head), .full(full), .empty(empty), .count(bus.fifo_count_out)
  );
  always_ff @(posedge clk_in)
    if (rst_in) begin
      div <= '0;
      period <= '0;
      level <= '0;
      underflow <= 1'b0;
    end else begin
      div <= tick ? 8'd0 : div + 8'd1;
      if (tick) period <= period + 8'd1;
      if (boundary) level <= empty ? '0 : process(head, bus.atten_in, rnd);
      underflow <= boundary && empty;
    end
`ifdef PWM_DITHER_EN
  logic [15:0] lfsr;
  always_ff @(posedge clk_in)
    if (rst_in) lfsr <= LFSR_SEED;
    else if (boundary) lfsr <= {^(lfsr & LFSR_TAPS), lfsr[15:1]};
  assign rnd = lfsr[7:0];
`else
  assign rnd = 8'd128;
`endif
endmodule

// File: doc/audio_pwm_feeder.md
AUDIO_PWM_FEEDER -- requirements
Module: audio_pwm_feeder

Interface
REQ-001 Parameter TICK_DIV, default 4: clk_in cycles per tick_out pulse; legal range 2..255.
REQ-002 Parameter FIFO_DEPTH, default 8: sample FIFO entries; power of two, 2..64.
REQ-003 clk_in  input  1  sole clock; all state updates on posedge.
REQ-004 rst_in  input  1  reset, synchronous, active-high.
REQ-005 sample_in  input  16  signed audio sample, two's complement.
REQ-006 sample_valid_in  input  1  sample_in is valid this cycle.
REQ-007 sample_ready_out  output  1  block accepts a sample this cycle.
REQ-008 atten_in  input  3  arithmetic right-shift attenuation, 0..7.
REQ-009 level_out  output  8  signed PWM level for downstream PWM stage.
REQ-010 tick_out  output  1  one-cycle PWM counter advance strobe.
REQ-011 underflow_out  output  1  one-cycle pulse: period boundary with FIFO empty.
REQ-012 fifo_count_out  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-013 Tick divider counts 0..TICK_DIV-1 and wraps; tick_out is high exactly in cycles where the divider equals TICK_DIV-1.
REQ-014 An 8-bit period counter increments on each tick_out and wraps 255->0, tracking the downstream PWM counter.
REQ-015 Period boundary = tick_out high AND period counter == 255; one boundary every 256*TICK_DIV cycles.
REQ-016 sample_ready_out = FIFO not full and rst_in low; push occurs when sample_valid_in and sample_ready_out are both high.
REQ-017 FIFO is first-word-fall-through; the head entry is visible combinationally for processing.
REQ-018 At a boundary with FIFO non-empty, the head is popped and level_out updates on that same clock edge to the processed head value.
REQ-019 At a boundary with FIFO empty, level_out becomes 0 on that edge and underflow_out is high for the following cycle only.
REQ-020 Between boundaries level_out holds its value.
REQ-021 Processing: s = sample >>> atten_in (16-bit arithmetic); r = s + 16'sd128 computed in 17 bits; level = r[15:8] saturated to -128..127.
REQ-022 Simultaneous push and pop: both occur; count unchanged. Push into empty FIFO on a boundary cycle is not visible to that boundary (underflow reported).
REQ-023 Push while full is impossible (ready low); sample_in ignored.
REQ-024 fifo_count_out reflects occupancy after each edge, 0..FIFO_DEPTH.

Reset
REQ-025 While rst_in high: divider 0, period counter 0, FIFO emptied, level_out 0, tick_out 0, underflow_out 0, sample_ready_out 0, fifo_count_out 0.
REQ-026 Reset mid-operation discards all queued samples; first tick_out occurs TICK_DIV cycles after rst_in falls.

Configuration
REQ-027 Macro PWM_DITHER_EN: when defined, a 16-bit Fibonacci LFSR (taps 16,14,13,11; reset seed 16'hACE1) advances once per boundary and its low 8 bits, zero-extended, replace the constant 128 in REQ-021.
REQ-028 Without PWM_DITHER_EN no LFSR exists and REQ-021 rounding is used unchanged.

Structure
REQ-029 Package audio_pkg holds sample/level widths, PERIOD_LEN = 256, LFSR seed and tap constants.
REQ-030 FIFO is a separate sub-module sample_fifo (parameterised depth, FWFT, push/pop/full/empty/count).

Verification (TICK_DIV=4, FIFO_DEPTH=8, dither off unless stated)
REQ-031 Reset held 5 cycles -> all outputs 0; after release tick_out pulses every 4th cycle; first boundary at cycle 1024.
REQ-032 Push 16'sh4000, atten 0 -> level_out = 8'sh40 from first boundary edge; fifo_count_out 1->0.
REQ-033 Push 16'sh7FF0 then 16'sh8000 -> level_out 8'sh7F (saturated) then 8'sh80 on successive boundaries.
REQ-034 Push 16'sh4000, atten 3 -> level_out 8'sh08; push 16'sh00C0, atten 0 -> 8'sh01 (round-up).
REQ-035 Push 9 back-to-back samples before any boundary -> ready low after 8th accept, count 8, 9th held; push accepted again in cycle after next boundary pop.
REQ-036 Empty FIFO at boundary after level 8'sh40 -> level_out 0, underflow_out high exactly one cycle; with PWM_DITHER_EN, constant input 16'sh0000 yields levels in {0} only and LFSR sequence matches seed 16'hACE1 model.
